// File: rtl/sprite_renderer_pkg.sv
// rtl/sprite_renderer_pkg.sv - shared types and constants for the sprite renderer
package sprite_renderer_pkg;

    localparam int PIX_W   = 12;
    localparam int ROW_W   = 5;
    localparam int COORD_W = 10;

    localparam logic [COORD_W-1:0] RST_POS_X = 10'd300;
    localparam logic [COORD_W-1:0] RST_POS_Y = 10'd200;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_ADDR,
        FETCH_LATCH
    } fetch_state_t;

    // Window extent along one axis; 11 bits so pos + extent never wraps.
    function automatic logic [COORD_W:0] win_size(input int base, input logic scale);
        return (COORD_W+1)'(base) << scale;
    endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// rtl/sprite_renderer_if.sv - video timing, position update, ROM and pixel bundle
`include "vga_params.vh"

interface sprite_renderer_if #(
    parameter int SPR_W = `VGA_SPR_W
);
    logic                pix_tick;
    logic                video_on;
    logic [9:0]          x;
    logic [9:0]          y;
    logic [11:0]         bg_rgb;
    logic                pos_load;
    logic [9:0]          new_x;
    logic [9:0]          new_y;
    logic                new_scale;
    logic [4:0]          rom_row;
    logic [SPR_W*12-1:0] rom_rgb;
    logic [11:0]         rgb_out;
    logic                hit;

    modport slave (
        input  pix_tick, video_on, x, y, bg_rgb,
        input  pos_load, new_x, new_y, new_scale,
        input  rom_rgb,
        output rom_row, rgb_out, hit
    );

    modport master (
        output pix_tick, video_on, x, y, bg_rgb,
        output pos_load, new_x, new_y, new_scale,
        output rom_rgb,
        input  rom_row, rgb_out, hit
    );
endinterface

// File: rtl/sprite_col_mux.sv
// rtl/sprite_col_mux.sv - selects one pixel from a packed sprite line, column 0 in the MSBs
module sprite_col_mux #(
    parameter int SPR_W = 40,
    parameter int PIX_W = 12,
    parameter int COL_W = 6
) (
    input  logic [SPR_W*PIX_W-1:0] line_data,
    input  logic [COL_W-1:0]       col,
    output logic [PIX_W-1:0]       pixel
);

    always_comb begin
        pixel = '0;
        for (int i = 0; i < SPR_W; i++) begin
            if (col == COL_W'(i)) begin
                pixel = line_data[SPR_W*PIX_W-1-PIX_W*i -: PIX_W];
            end
        end
    end

endmodule

// File: rtl/vga_params.vh
// rtl/vga_params.vh - shared VGA timing and sprite geometry defaults
`ifndef VGA_PARAMS_VH
`define VGA_PARAMS_VH
`define VGA_H_ACTIVE 640
`define VGA_V_ACTIVE 480
`define VGA_V_TOTAL  525
`define VGA_SPR_W    40
`define VGA_SPR_H    30
`define VGA_TRANSP   12'hfff
`endif

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - single sprite overlay with per-line ROM fetch and frame-synchronous moves
`include "vga_params.vh"

module sprite_renderer
    import sprite_renderer_pkg::*;
#(
    parameter int          H_ACTIVE = `VGA_H_ACTIVE,
    parameter int          V_ACTIVE = `VGA_V_ACTIVE,
    parameter int          V_TOTAL  = `VGA_V_TOTAL,
    parameter int          SPR_W    = `VGA_SPR_W,
    parameter int          SPR_H    = `VGA_SPR_H,
    parameter logic [11:0] TRANSP   = `VGA_TRANSP
) (
    input  logic             clk,
    input  logic             reset,
    sprite_renderer_if.slave bus
);

    localparam int LINE_W = SPR_W * PIX_W;
    localparam int COL_W  = $clog2(SPR_W);

    logic [COORD_W-1:0] pos_x, pos_y, pend_x, pend_y;
    logic               scale, pend_scale, pend;

    fetch_state_t       state;
    logic               in_range_r;
    logic               line_valid;
    logic [LINE_W-1:0]  line_buf;

    logic [COORD_W:0]   win_w, win_h, x_off, y_off;
    logic [COORD_W-1:0] ny;
    logic               in_x, in_y, commit;
    logic [COL_W-1:0]   col;
    logic [PIX_W-1:0]   pixel;

    always_comb begin
        win_w  = win_size(SPR_W, scale);
        win_h  = win_size(SPR_H, scale);
        ny     = (bus.y == COORD_W'(V_TOTAL-1)) ? '0 : bus.y + 10'd1;
        x_off  = {1'b0, bus.x} - {1'b0, pos_x};
        y_off  = {1'b0, ny} - {1'b0, pos_y};
        in_x   = (bus.x >= pos_x) && ({1'b0, bus.x} < {1'b0, pos_x} + win_w)
                 && (bus.x < COORD_W'(H_ACTIVE));
        in_y   = (ny >= pos_y) && ({1'b0, ny} < {1'b0, pos_y} + win_h);
        col    = COL_W'(x_off >> scale);
        commit = bus.pix_tick && pend && (bus.x == '0) && (bus.y == COORD_W'(V_ACTIVE));
    end

    // Moves are staged and only take effect at the start of vertical blanking,
    // so a frame never shows the sprite at two positions.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x      <= RST_POS_X;
            pos_y      <= RST_POS_Y;
            scale      <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
            pend_scale <= 1'b0;
            pend       <= 1'b0;
        end else begin
            if (commit) begin
                pos_x <= pend_x;
                pos_y <= pend_y;
                scale <= pend_scale;
            end
            if (bus.pos_load) begin
                pend_x     <= bus.new_x;
                pend_y     <= bus.new_y;
                pend_scale <= bus.new_scale;
                pend       <= 1'b1;
            end else if (commit) begin
                pend <= 1'b0;
            end
        end
    end

    // The ROM answers combinationally, so its data is captured while the row
    // address is still being driven; line_valid follows one clock later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_IDLE;
            bus.rom_row <= '0;
            in_range_r  <= 1'b0;
            line_valid  <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (bus.pix_tick && bus.x == COORD_W'(H_ACTIVE)) begin
                        bus.rom_row <= ROW_W'(y_off >> scale);
                        in_range_r  <= in_y;
                        state       <= FETCH_ADDR;
                    end
                end
                FETCH_ADDR: begin
                    line_buf    <= bus.rom_rgb;
                    bus.rom_row <= '0;
                    state       <= FETCH_LATCH;
                end
                FETCH_LATCH: begin
                    line_valid <= in_range_r;
                    state      <= FETCH_IDLE;
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    sprite_col_mux #(
        .SPR_W (SPR_W),
        .PIX_W (PIX_W),
        .COL_W (COL_W)
    ) u_col_mux (
        .line_data (line_buf),
        .col       (col),
        .pixel     (pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rgb_out <= '0;
            bus.hit     <= 1'b0;
        end else if (bus.pix_tick) begin
            if (!bus.video_on) begin
                bus.rgb_out <= '0;
                bus.hit     <= 1'b0;
            end else if (line_valid && in_x && pixel != TRANSP) begin
                bus.rgb_out <= pixel;
                bus.hit     <= 1'b1;
            end else begin
                bus.rgb_out <= bus.bg_rgb;
                bus.hit     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - randomized scoreboard bench for sprite_renderer
module tb_sprite_renderer;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int SPR_W    = 40;
    localparam int SPR_H    = 30;
    localparam logic [11:0] TRANSP = 12'hfff;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
        logic        hit;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_renderer_if ifc ();

    sprite_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    logic [11:0] rom [32][SPR_W];

    always_comb begin
        ifc.rom_rgb = '0;
        for (int c = 0; c < SPR_W; c++) begin
            ifc.rom_rgb[SPR_W*12-1-12*c -: 12] = rom[ifc.rom_row][c];
        end
    end

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_px, m_py, m_sc, m_npx, m_npy, m_nsc, m_row;
    bit m_pend, m_lv;
    int ld_x, ld_y, ld_s;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_px = 300; m_py = 200; m_sc = 0;
        m_pend = 0; m_lv = 0; m_row = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ifc.pix_tick = 1'b0;
            ifc.pos_load = 1'b0;
        end
    endtask

    // One pixel tick plus the model's view of what that tick means.
    task automatic pix(input int xx, input int yy, input bit vo, input bit ld);
        exp_t        e;
        logic [11:0] bg, p;
        int          w, h, ny;
        @(negedge clk);
        bg = 12'($urandom);
        ifc.pix_tick  = 1'b1;
        ifc.x         = 10'(xx);
        ifc.y         = 10'(yy);
        ifc.video_on  = vo;
        ifc.bg_rgb    = bg;
        ifc.pos_load  = ld;
        ifc.new_x     = 10'(ld_x);
        ifc.new_y     = 10'(ld_y);
        ifc.new_scale = ld_s[0];
        w = SPR_W << m_sc;
        e.x = xx; e.y = yy; e.rgb = bg; e.hit = 1'b0;
        if (!vo) begin
            e.rgb = '0;
        end else if (m_lv && xx >= m_px && xx < m_px + w && xx < H_ACTIVE) begin
            p = rom[m_row][(xx - m_px) >> m_sc];
            if (p != TRANSP) begin
                e.rgb = p;
                e.hit = 1'b1;
            end
        end
        sb.push_back(e);
        if (xx == H_ACTIVE) begin
            ny    = (yy == V_TOTAL - 1) ? 0 : yy + 1;
            h     = SPR_H << m_sc;
            m_lv  = (ny >= m_py) && (ny < m_py + h);
            m_row = m_lv ? ((ny - m_py) >> m_sc) : 0;
        end
        if (xx == 0 && yy == V_ACTIVE && m_pend) begin
            m_px = m_npx; m_py = m_npy; m_sc = m_nsc; m_pend = 0;
        end
        if (ld) begin
            m_npx = ld_x; m_npy = ld_y; m_nsc = ld_s; m_pend = 1;
        end
    endtask

    task automatic load(input int nx, input int ny, input int ns);
        ld_x = nx; ld_y = ny; ld_s = ns;
        @(negedge clk);
        ifc.pix_tick  = 1'b0;
        ifc.pos_load  = 1'b1;
        ifc.new_x     = 10'(nx);
        ifc.new_y     = 10'(ny);
        ifc.new_scale = ns[0];
        m_npx = nx; m_npy = ny; m_nsc = ns; m_pend = 1;
    endtask

    task automatic run_line(input int yy, input bit blank_extra, input bit ld0, input bit rst_addr);
        int xs[8];
        int w;
        w  = SPR_W << m_sc;
        xs = '{0, 1, m_px, m_px + w - 1, m_px + w, 315,
               $urandom_range(0, H_ACTIVE - 1), $urandom_range(m_px, m_px + w)};
        for (int i = 0; i < 8; i++) begin
            if (xs[i] < H_ACTIVE) begin
                pix(xs[i], yy, (yy < V_ACTIVE) && (i < 6 || $urandom_range(0, 3) != 0), ld0 && i == 0);
            end
        end
        if (blank_extra) pix(315, yy, 1'b0, 1'b0);
        pix(H_ACTIVE, yy, 1'b0, 1'b0);
        if (rst_addr) begin
            @(negedge clk);
            ifc.pix_tick = 1'b0;
            check("rom_row_in_addr", int'(ifc.rom_row), m_row);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("rom_row_after_abort", int'(ifc.rom_row), 0);
            check("rgb_after_abort", int'(ifc.rgb_out), 0);
            check("hit_after_abort", int'(ifc.hit), 0);
            model_reset();
            idle(2);
        end else begin
            idle(3);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: every clock that carried a pixel tick owes one scoreboard entry.
    initial begin
        exp_t e;
        bit   t;
        forever begin
            @(posedge clk);
            t = ifc.pix_tick && !reset;
            @(negedge clk);
            if (t) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: output with no expected entry");
                end else begin
                    e = sb.pop_front();
                    if (ifc.rgb_out !== e.rgb || ifc.hit !== e.hit) begin
                        n_fail++;
                        $display("FAIL pixel (%0d,%0d): got rgb=%h hit=%b expected rgb=%h hit=%b",
                                 e.x, e.y, ifc.rgb_out, ifc.hit, e.rgb, e.hit);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] v;
        ifc.pix_tick = 0; ifc.video_on = 0; ifc.x = 0; ifc.y = 0; ifc.bg_rgb = 0;
        ifc.pos_load = 0; ifc.new_x = 0; ifc.new_y = 0; ifc.new_scale = 0;
        ld_x = 0; ld_y = 0; ld_s = 0;
        m_npx = 0; m_npy = 0; m_nsc = 0;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < SPR_W; c++) begin
                v = 12'($urandom);
                if (v == TRANSP) v = 12'h000;
                rom[r][c] = ($urandom_range(0, 3) == 0) ? TRANSP : v;
            end
        end
        rom[0][0]  = TRANSP;
        rom[9][15] = 12'h6bf;

        do_reset();
        check("reset_rgb", int'(ifc.rgb_out), 0);
        check("reset_hit", int'(ifc.hit), 0);
        check("reset_rom_row", int'(ifc.rom_row), 0);

        for (int f = 0; f < 7; f++) begin
            for (int yy = 0; yy < V_TOTAL; yy++) begin
                if (yy == 300) begin
                    case (f)
                        0: load(100, 50, 0);
                        1: load(0, 0, 1);
                        2: load(620, 470, 0);
                        3, 4: load($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1));
                        default: ;
                    endcase
                end
                if (f == 4 && yy == V_ACTIVE) begin
                    ld_x = 1010; ld_y = $urandom_range(0, V_ACTIVE - 1); ld_s = 1;
                end
                run_line(yy, f == 0 && yy == 209, f == 4 && yy == V_ACTIVE, 1'b0);
            end
        end

        do_reset();
        for (int yy = 0; yy < 213; yy++) begin
            run_line(yy, 1'b0, 1'b0, yy == 209);
        end

        idle(3);
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, lines per frame.
- SPR_W, 40, sprite columns.
- SPR_H, 30, sprite rows.
- TRANSP, 12'hfff, transparent colour.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- pix_tick, in, 1, pixel enable.
- video_on, in, 1, active display.
- x, in, 10, current pixel column.
- y, in, 10, current line.
- bg_rgb, in, 12, background colour.
- pos_load, in, 1, position update strobe.
- new_x, in, 10, requested sprite left edge.
- new_y, in, 10, requested sprite top edge.
- new_scale, in, 1, requested scale (0=1x, 1=2x).
- rom_row, out, 5, ROM row address.
- rom_rgb, in, 480, ROM row data (combinational).
- rgb_out, out, 12, pixel colour.
- hit, out, 1, opaque sprite pixel shown.
REQ-003 Clocking and reset: one clock, clk; reset is synchronous and active-high.

Function
REQ-004 Active registers pos_x, pos_y and scale define the sprite window: width SPR_W<<scale, height SPR_H<<scale.
REQ-005 A pos_load pulse on any clk captures new_x, new_y and new_scale into pending registers and sets pend=1; a later pos_load overwrites the pending values.
REQ-006 On a pix_tick with x==0 and y==V_ACTIVE with pend=1, the pending values are copied to the active registers and pend is cleared. A pos_load in that same cycle is kept pending for the next frame.
REQ-007 Line fetch FSM has three states.
- IDLE -> ADDR: on a pix_tick with x==H_ACTIVE. The FSM computes ny = (y==V_TOTAL-1) ? 0 : y+1, and r = (ny-pos_y)>>scale.
- ADDR: drives rom_row=r for exactly one clk, then goes to LATCH.
- LATCH: loads rom_rgb into the 480-bit line buffer and sets line_valid = (ny>=pos_y && ny<pos_y+(SPR_H<<scale)), then returns to IDLE.
REQ-008 While no row is being fetched, rom_row=0. When ny is out of range, line_valid=0 and the fetched data is ignored.
REQ-009 Column c=(x-pos_x)>>scale. The selected pixel is buffer bits [479-12c -: 12], so column 0 is the MSBs.
REQ-010 rgb_out and hit update only on pix_tick; latency is 1 pix_tick from the x,y sample.
- video_on=0: rgb_out=0 and hit=0.
- Otherwise, if line_valid and x is inside the window and the pixel != TRANSP: rgb_out=pixel and hit=1.
- Otherwise: rgb_out=bg_rgb and hit=0.
REQ-011 Window comparisons use 11-bit arithmetic, so pos_x+width beyond 1023 does not wrap. Columns at or beyond H_ACTIVE are never shown.
REQ-012 A sprite with pos_y=0 fetches its row 0 at line V_TOTAL-1, so it is valid from line 0.

Reset
REQ-013 Reset clears the following: rgb_out=0, hit=0, rom_row=0, FSM=IDLE, line_valid=0, pend=0.
REQ-014 Reset sets pos_x=300, pos_y=200, scale=0; the line buffer contents are don't-care.
REQ-015 Reset asserted mid-fetch aborts the fetch, and the next line shows background.

Structure
REQ-016 H_ACTIVE, V_ACTIVE, V_TOTAL, SPR_W, SPR_H and TRANSP live in a shared include file, vga_params.vh.
REQ-017 The ROM sits outside the block and connects through rom_row/rom_rgb. One sub-module, sprite_col_mux, performs the combinational 40:1 12-bit column select.

Verification
REQ-018 Reset, then frame with default position: pixel (300,200) equals ROM row 0 col 0 → rgb_out=bg_rgb, hit=0 (white is transparent); pixel (315,209) → rgb_out=12'h6bf, hit=1.
REQ-019 pos_load new_x=100,new_y=50 mid-frame at line 300 → current frame still renders at (300,200); next frame renders at (100,50); pend clears at line 480.
REQ-020 new_scale=1, pos (0,0) → pixels (0..1, 0..1) carry ROM row0 col0, and rows 0-1 both map to ROM row 0; the window is 80x60.
REQ-021 pos (620,470) → only columns 620-639 and lines 470-479 show sprite; no wrap to column 0 or line 0.
REQ-022 video_on=0 during an in-window pixel → rgb_out=0, hit=0; reset asserted during ADDR → rom_row=0 next clk and the next line shows bg_rgb.
